// File: rtl/atm_pkg.sv
// atm_pkg: shared arbiter state type, button indices and default timing constants
package atm_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, HOLD} arb_state_e;
   localparam int BTN1_IDX = 0;
   localparam int BTN2_IDX = 1;
   localparam int BTN3_IDX = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int DEFAULT_TIMEOUT_CYCLES = 200;
endpackage

// File: rtl/atm_debounce.sv
// atm_debounce: 2-flop synchroniser plus stable-count debouncer for one pushbutton
module atm_debounce
   import atm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   logic sync1_q, sync2_q, level_q;
   logic [CW-1:0] cnt_q;
   // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            level_q <= ~level_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end
   assign level_o = level_q;
endmodule

// File: rtl/atm_input_arbiter.sv
// atm_input_arbiter: debounced, arbitrated single-pulse button requests with idle auto-cancel
module atm_input_arbiter
   import atm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn3_raw,
   input  logic       btn2_raw,
   input  logic       btn1_raw,
   input  logic [3:0] sw_raw,
   input  logic       session_active,
   output logic       BTN3,
   output logic       BTN2,
   output logic       BTN1,
   output logic [3:0] SW,
   output logic       timeout,
   output logic       busy
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT_CYCLES - 1);
   arb_state_e state_q, state_d;
   logic [2:0] raw, level, level_q, rise, pend_q, pend_d, grant_q, grant_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [3:0] sw_s1_q, sw_s2_q, sw_q, sw_d;
   logic timeout_q, timeout_d, busy_q;
   assign raw = {btn3_raw, btn2_raw, btn1_raw};
   for (genvar g = 0; g < 3; g++) begin : g_db
      atm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk(clk),
         .rst(rst),
         .raw_i(raw[g]),
         .level_o(level[g])
      );
   end
   assign rise = level & ~level_q;
   // Arbiter next state: real presses beat expiry; lowest index (BTN1) has top priority
   always_comb begin
      state_d = state_q;
      pend_d = pend_q | rise;
      cnt_d = '0;
      grant_d = '0;
      timeout_d = 1'b0;
      sw_d = sw_q;
      unique case (state_q)
         IDLE: begin
            if (|pend_q) begin
               state_d = GRANT;
               pend_d = '0;
               sw_d = sw_s2_q;
               grant_d = pend_q & (~pend_q + 3'd1);
            end else if (session_active && cnt_q == CNT_MAX) begin
               state_d = GRANT;
               pend_d = '0;
               sw_d = sw_s2_q;
               grant_d[BTN1_IDX] = 1'b1;
               timeout_d = 1'b1;
            end else if (session_active) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GRANT: begin
            state_d = HOLD;
            pend_d = '0;
         end
         HOLD: begin
            pend_d = '0;
            state_d = (level == '0) ? IDLE : HOLD;
         end
         default: state_d = IDLE;
      endcase
   end
   // Registered state, pending bits, outputs and switch synchroniser/snapshot
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         level_q <= '0;
         pend_q <= '0;
         cnt_q <= '0;
         grant_q <= '0;
         timeout_q <= 1'b0;
         busy_q <= 1'b0;
         sw_s1_q <= '0;
         sw_s2_q <= '0;
         sw_q <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level;
         pend_q <= pend_d;
         cnt_q <= cnt_d;
         grant_q <= grant_d;
         timeout_q <= timeout_d;
         busy_q <= (state_d != IDLE);
         sw_s1_q <= sw_raw;
         sw_s2_q <= sw_s1_q;
         sw_q <= sw_d;
      end
   end
   assign BTN1 = grant_q[BTN1_IDX];
   assign BTN2 = grant_q[BTN2_IDX];
   assign BTN3 = grant_q[BTN3_IDX];
   assign SW = sw_q;
   assign timeout = timeout_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_atm_input_arbiter.sv
// tb_atm_input_arbiter: directed and random stimulus checked against a cycle reference model
module tb_atm_input_arbiter;
   localparam int D = 4;
   localparam int T = 200;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn3_raw = 1'b0, btn2_raw = 1'b0, btn1_raw = 1'b0, session_active = 1'b0;
   logic [3:0] sw_raw = 4'h0;
   logic BTN3, BTN2, BTN1, timeout, busy;
   logic [3:0] SW;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;
   atm_input_arbiter #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk),
      .rst(rst),
      .btn3_raw(btn3_raw),
      .btn2_raw(btn2_raw),
      .btn1_raw(btn1_raw),
      .sw_raw(sw_raw),
      .session_active(session_active),
      .BTN3(BTN3),
      .BTN2(BTN2),
      .BTN1(BTN1),
      .SW(SW),
      .timeout(timeout),
      .busy(busy)
   );
   // reference model: index 0 = BTN1 (highest priority), 1 = BTN2, 2 = BTN3
   bit [2:0] m_d1, m_d2, m_lvl, m_lvlp, m_pend, m_btn;
   int m_run[3];
   logic [3:0] m_sw1, m_sw2, m_sw;
   int m_phase;
   int m_cnt;
   bit m_to;
   task automatic model_edge();
      bit [2:0] rawv, rise, lvl_old;
      int pick;
      rawv = {btn3_raw, btn2_raw, btn1_raw};
      if (!rst) begin
         m_d1 = 0; m_d2 = 0; m_lvl = 0; m_lvlp = 0; m_pend = 0; m_btn = 0;
         m_run = '{0, 0, 0};
         m_sw1 = 0; m_sw2 = 0; m_sw = 0; m_phase = 0; m_cnt = 0; m_to = 0;
         return;
      end
      rise = m_lvl & ~m_lvlp;
      lvl_old = m_lvl;
      m_lvlp = m_lvl;
      for (int b = 0; b < 3; b++) begin
         if (m_d2[b] == m_lvl[b]) m_run[b] = 0;
         else begin
            m_run[b]++;
            if (m_run[b] == D) begin m_lvl[b] = ~m_lvl[b]; m_run[b] = 0; end
         end
      end
      m_d2 = m_d1;
      m_d1 = rawv;
      m_btn = 0;
      m_to = 0;
      if (m_phase == 0) begin
         if (m_pend != 0) begin
            pick = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
            m_btn[pick] = 1; m_sw = m_sw2; m_pend = 0; m_phase = 1; m_cnt = 0;
         end else if (session_active && m_cnt == T - 1) begin
            m_btn[0] = 1; m_to = 1; m_sw = m_sw2; m_phase = 1; m_cnt = 0;
         end else begin
            m_cnt = session_active ? m_cnt + 1 : 0;
            m_pend = rise;
         end
      end else if (m_phase == 1) begin
         m_phase = 2; m_pend = 0; m_cnt = 0;
      end else begin
         m_pend = 0;
         if (lvl_old == 0) m_phase = 0;
      end
      m_sw2 = m_sw1;
      m_sw1 = sw_raw;
   endtask
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("BTN1", BTN1, m_btn[0]);
      chk("BTN2", BTN2, m_btn[1]);
      chk("BTN3", BTN3, m_btn[2]);
      chk("timeout", timeout, m_to);
      chk("busy", busy, m_phase != 0);
      chk("SW", SW, m_sw);
   endtask
   initial begin
      int first, n1, n2, n3, nto, tail, seen;
      repeat (3) step();
      chk("reset_btns", {BTN3, BTN2, BTN1}, 0);
      chk("reset_sw", SW, 0);
      rst = 1'b1;
      repeat (5) step();
      // clean press of BTN3 with switches at A
      sw_raw = 4'hA; btn3_raw = 1'b1; first = 0; n3 = 0; tail = 0;
      for (int n = 1; n <= 40; n++) begin
         if (n == 21) btn3_raw = 1'b0;
         step();
         if (BTN3) begin
            n3++;
            if (first == 0) first = n;
            chk("clean_sw", SW, 4'hA);
         end
         if (n >= 21 && busy) tail++;
      end
      chk("clean_latency", first, D + 4);
      chk("clean_count", n3, 1);
      chk("clean_busy_tail", tail, D + 2);
      // bouncing BTN2, then held
      first = 0; n2 = 0;
      for (int n = 1; n <= 50; n++) begin
         btn2_raw = (n <= 12) ? (((n - 1) / 2) % 2 == 0) : (n < 33);
         step();
         if (BTN2) begin n2++; if (first == 0) first = n; end
      end
      chk("bounce_latency", first, 13 + D + 3);
      chk("bounce_count", n2, 1);
      // simultaneous BTN2+BTN3, then BTN3 alone
      n2 = 0; n3 = 0;
      for (int n = 1; n <= 40; n++) begin
         btn2_raw = (n <= 20); btn3_raw = (n <= 20);
         step();
         n2 += int'(BTN2); n3 += int'(BTN3);
      end
      chk("simul_btn2", n2, 1);
      chk("simul_btn3", n3, 0);
      n2 = 0; n3 = 0;
      for (int n = 1; n <= 40; n++) begin
         btn3_raw = (n <= 20);
         step();
         n2 += int'(BTN2); n3 += int'(BTN3);
      end
      chk("alone_btn3", n3, 1);
      chk("alone_btn2", n2, 0);
      // idle session timeout
      session_active = 1'b1; sw_raw = 4'h5; first = 0; nto = 0;
      for (int n = 1; n <= T + 20; n++) begin
         step();
         if (timeout) begin
            nto++;
            if (first == 0) first = n;
            chk("to_btn1", BTN1, 1);
            chk("to_sw", SW, 4'h5);
         end
      end
      chk("to_cycle", first, T);
      chk("to_count", nto, 1);
      session_active = 1'b0; nto = 0; n1 = 0;
      for (int n = 1; n <= 500; n++) begin
         step();
         nto += int'(timeout); n1 += int'(BTN1);
      end
      chk("no_session_to", nto, 0);
      chk("no_session_btn1", n1, 0);
      // press whose pending bit lands in the expiry cycle
      session_active = 1'b1;
      for (int i = 0; i < 2 * T && m_cnt != T - D - 4; i++) step();
      chk("race_armed", m_cnt, T - D - 4);
      btn3_raw = 1'b1; n3 = 0; nto = 0; n1 = 0;
      for (int n = 1; n <= 30; n++) begin
         if (n == 20) btn3_raw = 1'b0;
         step();
         n3 += int'(BTN3); nto += int'(timeout); n1 += int'(BTN1);
      end
      chk("race_btn3", n3, 1);
      chk("race_timeout", nto, 0);
      chk("race_btn1", n1, 0);
      session_active = 1'b0;
      repeat (20) step();
      // reset while BTN1 is held in HOLD
      btn1_raw = 1'b1; seen = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (BTN1) seen = 1;
         else if (seen == 1 && busy) begin seen = 2; break; end
      end
      chk("hold_reached", seen, 2);
      rst = 1'b0;
      step();
      chk("rst_btns", {timeout, BTN3, BTN2, BTN1}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sw", SW, 0);
      rst = 1'b1; first = 0; n1 = 0;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (BTN1) begin n1++; if (first == 0) first = n; end
      end
      chk("rst_repulse_latency", first, D + 4);
      chk("rst_repulse_count", n1, 1);
      btn1_raw = 1'b0;
      repeat (20) step();
      // random bouncing buttons, switches, sessions and rare resets
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 11) == 0) btn1_raw = ~btn1_raw;
         if ($urandom_range(0, 11) == 0) btn2_raw = ~btn2_raw;
         if ($urandom_range(0, 11) == 0) btn3_raw = ~btn3_raw;
         if ($urandom_range(0, 149) == 0) session_active = ~session_active;
         if ($urandom_range(0, 3) == 0) sw_raw = 4'($urandom);
         rst = ($urandom_range(0, 399) != 0);
         step();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/atm_input_arbiter.md
# atm_input_arbiter

Front-end controller placed between the board pushbuttons/switches and the `atm` transaction FSM. It synchronises and debounces BTN3/BTN2/BTN1, converts each press into a single-cycle request pulse, and arbitrates simultaneous presses so the FSM sees at most one button per cycle. It presents a SW snapshot that stays stable while the pulse is high, and injects a cancel (BTN1) when an open session has been idle too long.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles needed before a debounced level changes (≥1).
- `TIMEOUT_CYCLES`, default 200: idle cycles in an active session before an auto-cancel is issued (≥2).
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `btn3_raw`, `btn2_raw`, `btn1_raw`  in  1 each  asynchronous, bouncing pushbuttons.
- `sw_raw`  in  4  asynchronous slide switches.
- `session_active`  in  1  high while `atm` is past PIN entry (OPEN and later states).
- `BTN3`, `BTN2`, `BTN1`  out  1 each  one-cycle request pulses; at most one high per cycle.
- `SW`  out  4  switch snapshot; valid and stable whenever any BTN pulse is high.
- `timeout`  out  1  one-cycle pulse, coincident with an injected BTN1.
- `busy`  out  1  high in GRANT and HOLD.

## Operation
- Per button: 2-flop synchroniser, then a debouncer. The debounced level flips only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing cycle clears the count.
- A rising edge of a debounced level sets that button's pending bit.
- `sw_raw` passes through a 2-flop synchroniser only. It is not debounced.
- Arbiter FSM states:
  - IDLE: if any pending bit is set, grant the highest priority (BTN1 > BTN2 > BTN3), latch the synchronised switches into `SW`, clear all pending bits (losers are discarded), and go to GRANT.
  - GRANT: the granted output is high for exactly this cycle. Next state is HOLD.
  - HOLD: stay until all three debounced levels are 0, then return to IDLE. Pending bits set during HOLD are cleared. A held button therefore yields exactly one pulse.
- Timeout counter:
  - Increments each IDLE cycle while `session_active`=1 and no pending bit is set.
  - Clears on any grant, on `session_active`=0, or in GRANT/HOLD.
  - When it reaches `TIMEOUT_CYCLES`−1 in IDLE: load `SW` with the current synchronised switches, go to GRANT with BTN1 selected, assert `timeout` together with `BTN1`, and clear the counter.
- Simultaneous events:
  - A real press that becomes pending in the same cycle as expiry wins. No `timeout` is asserted and the counter clears.
  - Two buttons whose debounced edges occur in the same cycle: only the higher-priority one is pulsed.
- `SW` holds its value between grants. It changes only on the IDLE→GRANT transition.

## Timing
- Reset values: `BTN3`/`BTN2`/`BTN1`/`timeout`/`busy` = 0, `SW` = 0, FSM = IDLE. All synchronisers, debounced levels, pending bits and counters are 0.
- Press latency: with a clean raw rise first sampled at edge k, the pulse is high in the cycle after edge k+`DEBOUNCE_CYCLES`+3 (total `DEBOUNCE_CYCLES`+4 edges; 8 at default).
- Release latency: HOLD exits `DEBOUNCE_CYCLES`+2 edges after the last raw release, then spends one cycle in IDLE. The minimum spacing between two pulses is therefore `DEBOUNCE_CYCLES`+4 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset asserted mid-GRANT or mid-HOLD:
  - Outputs drop to reset values on the next edge.
  - A button still held through reset generates a new pulse after release of reset, because its debounced level restarts at 0.

## Structure
- Shared package `atm_pkg` holds:
  - the arbiter state typedef (IDLE, GRANT, HOLD);
  - button index constants (`BTN1_IDX`=0, `BTN2_IDX`=1, `BTN3_IDX`=2);
  - the default `DEBOUNCE_CYCLES` and `TIMEOUT_CYCLES` constants.
- One sub-module, `atm_debounce`, containing the synchroniser, counter and debounced level. It is parameterised by `DEBOUNCE_CYCLES` and instantiated three times.
- Arbitration, `SW` latch and timeout stay in the top module.

## Test plan
- Clean press: `btn3_raw`=1 for 20 cycles with `sw_raw`=4'hA, D=4 → exactly one `BTN3` pulse 8 cycles after the rise, `SW`=4'hA during the pulse, `busy` high until release +6 cycles.
- Bounce: `btn2_raw` toggles every 2 cycles for 12 cycles, then is held 1 → no pulse during the bounce; one `BTN2` pulse 8 cycles after the final rise.
- Simultaneous: `btn2_raw` and `btn3_raw` rise in the same cycle → only `BTN2` pulses. Releasing both and pressing `btn3_raw` alone → `BTN3` pulses.
- Timeout: `session_active`=1, no buttons, T=200 → `BTN1` and `timeout` both high in the single cycle at the 200th IDLE cycle. With `session_active`=0 for 500 cycles → no timeout.
- Timeout race: a press is timed so its pending bit sets in the expiry cycle → button pulse only, `timeout`=0.
- Reset mid-HOLD: hold `btn1_raw`, pulse `rst`=0 for 1 cycle → all outputs 0 next edge, then a second `BTN1` pulse 8 cycles after reset deasserts.
